// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_light_monitor
//  Description : Receive-side checker for the two-road traffic light bus.
//                It decodes the lamp patterns into phases P1..P4 and checks
//                encoding, safety conflicts and phase order. The first fault
//                is latched and held until clr.
//                The optional dwell-time checks are enabled by defining
//                TRAFFIC_MON_TIMING_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_light_monitor #(
    parameter int unsigned LONG_CYC  = 800_000_001,
    parameter int unsigned SHORT_CYC = 200_000_001,
    parameter int unsigned TOL       = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] light1,
    input  logic [1:0] light2,
    input  logic       clr,
    output logic [1:0] phase,
    output logic       phase_valid,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] cycle_cnt
);

    // Monitor states
    localparam logic [1:0] c_ST_OFF   = 2'd0;
    localparam logic [1:0] c_ST_SYNC  = 2'd1;
    localparam logic [1:0] c_ST_RUN   = 2'd2;
    localparam logic [1:0] c_ST_FAULT = 2'd3;

    // Decoded lamp pattern classes
    localparam logic [2:0] c_PAT_OFF  = 3'd0;
    localparam logic [2:0] c_PAT_G2   = 3'd1;
    localparam logic [2:0] c_PAT_Y    = 3'd2;
    localparam logic [2:0] c_PAT_G1   = 3'd3;
    localparam logic [2:0] c_PAT_CONF = 3'd4;
    localparam logic [2:0] c_PAT_BAD  = 3'd5;

    // Fault codes; a lower number has the higher priority
    localparam logic [2:0] c_CODE_NONE  = 3'd0;
    localparam logic [2:0] c_CODE_CONF  = 3'd1;
    localparam logic [2:0] c_CODE_ENC   = 3'd2;
    localparam logic [2:0] c_CODE_SEQ   = 3'd3;
    localparam logic [2:0] c_CODE_SHORT = 3'd4;
    localparam logic [2:0] c_CODE_LONG  = 3'd5;

    // Reject parameter sets for which the dwell window cannot be evaluated
    // with the 30-bit dwell counter.
    generate
        if ((TOL >= SHORT_CYC) || (TOL >= LONG_CYC) ||
            (LONG_CYC + TOL >= 32'h3FFF_FFFF) ||
            (SHORT_CYC + TOL >= 32'h3FFF_FFFF)) begin : g_param_err
            $error("traffic_light_monitor: TOL must be below both dwell targets and EXP+TOL+1 must fit in 30 bits");
        end
    endgenerate

    logic [1:0] r_state;
    logic [1:0] r_phase;
    logic       r_valid;
    logic       r_fault;
    logic [2:0] r_code;
    logic [7:0] r_cnt;

    logic [2:0] w_cls;
    logic [2:0] w_cur_cls;
    logic [2:0] w_nxt_cls;
    logic [1:0] w_nxt_phase;
    logic [2:0] w_code;
    logic       w_short;
    logic       w_long;

    assign phase       = r_phase;
    assign phase_valid = r_valid;
    assign fault       = r_fault;
    assign fault_code  = r_code;
    assign cycle_cnt   = r_cnt;

    // Classify the incoming lamp pattern
    always_comb begin
        w_cls = c_PAT_BAD;
        if (light2 == 2'b01) begin
            // Road 2 green is only safe while road 1 shows red
            w_cls = (light1 == 3'b100) ? c_PAT_G2 : c_PAT_CONF;
        end else if ((light1 == 3'b000) && (light2 == 2'b00)) begin
            w_cls = c_PAT_OFF;
        end else if (light2 == 2'b10) begin
            if (light1 == 3'b010)      w_cls = c_PAT_Y;
            else if (light1 == 3'b001) w_cls = c_PAT_G1;
            else                       w_cls = c_PAT_BAD;
        end
    end

    // Pattern of the tracked phase and of its legal successor; yellow is
    // shared by P2 and P4, so the tracked phase resolves the ambiguity.
    always_comb begin
        w_cur_cls   = c_PAT_G2;
        w_nxt_cls   = c_PAT_Y;
        w_nxt_phase = 2'd1;
        case (r_phase)
            2'd0: begin w_cur_cls = c_PAT_G2; w_nxt_cls = c_PAT_Y;  w_nxt_phase = 2'd1; end
            2'd1: begin w_cur_cls = c_PAT_Y;  w_nxt_cls = c_PAT_G1; w_nxt_phase = 2'd2; end
            2'd2: begin w_cur_cls = c_PAT_G1; w_nxt_cls = c_PAT_Y;  w_nxt_phase = 2'd3; end
            default: begin w_cur_cls = c_PAT_Y; w_nxt_cls = c_PAT_G2; w_nxt_phase = 2'd0; end
        endcase
    end

`ifdef TRAFFIC_MON_TIMING_EN
    logic [4:0]  r_prev_pat;
    logic [29:0] r_dwell;
    logic        w_pat_chg;
    logic [31:0] w_exp;

    assign w_pat_chg = ({light1, light2} != r_prev_pat);
    // Yellow phases (P2/P4, odd phase numbers) use the short target
    assign w_exp     = r_phase[0] ? SHORT_CYC : LONG_CYC;
    assign w_short   = w_pat_chg && ({2'b00, r_dwell} < (w_exp - TOL));
    assign w_long    = ({2'b00, r_dwell} >= (w_exp + TOL + 32'd1));

    // Dwell counter: cycles of an unchanged pattern, saturating
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_pat <= 5'd0;
            r_dwell    <= 30'd0;
        end else begin
            r_prev_pat <= {light1, light2};
            if (w_pat_chg)      r_dwell <= 30'd0;
            else if (~&r_dwell) r_dwell <= r_dwell + 30'd1;
        end
    end
`else
    assign w_short = 1'b0;
    assign w_long  = 1'b0;
`endif

    // Highest-priority fault raised by the current pattern (NONE if legal)
    always_comb begin
        w_code = c_CODE_NONE;
        if (w_cls == c_PAT_CONF) begin
            w_code = c_CODE_CONF;
        end else if (w_cls == c_PAT_BAD) begin
            w_code = c_CODE_ENC;
        end else if (w_cls != c_PAT_OFF) begin
            case (r_state)
                c_ST_OFF: begin
                    if (w_cls != c_PAT_G2) w_code = c_CODE_SEQ;
                end
                c_ST_SYNC, c_ST_RUN: begin
                    if (w_cls == w_cur_cls) begin
                        if ((r_state == c_ST_RUN) && w_long) w_code = c_CODE_LONG;
                    end else if (w_cls == w_nxt_cls) begin
                        if ((r_state == c_ST_RUN) && w_short)     w_code = c_CODE_SHORT;
                        else if ((r_state == c_ST_RUN) && w_long) w_code = c_CODE_LONG;
                    end else begin
                        w_code = c_CODE_SEQ;
                    end
                end
                default: w_code = c_CODE_NONE;
            endcase
        end
    end

    // Monitor FSM with registered phase, fault and cycle outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_OFF;
            r_phase <= 2'd0;
            r_valid <= 1'b0;
            r_fault <= 1'b0;
            r_code  <= c_CODE_NONE;
            r_cnt   <= 8'd0;
        end else begin
            case (r_state)
                c_ST_FAULT: begin
                    // Only clr is honoured; a bad pattern present with clr relatches
                    if (clr) begin
                        if (w_code != c_CODE_NONE) begin
                            r_code <= w_code;
                        end else begin
                            r_state <= c_ST_OFF;
                            r_phase <= 2'd0;
                            r_valid <= 1'b0;
                            r_fault <= 1'b0;
                            r_code  <= c_CODE_NONE;
                        end
                    end
                end
                default: begin
                    if (w_code != c_CODE_NONE) begin
                        r_state <= c_ST_FAULT;
                        r_valid <= 1'b0;
                        r_fault <= 1'b1;
                        r_code  <= w_code;
                    end else if (w_cls == c_PAT_OFF) begin
                        // Legal shutdown; the cycle count is kept
                        r_state <= c_ST_OFF;
                        r_phase <= 2'd0;
                        r_valid <= 1'b0;
                    end else if (r_state == c_ST_OFF) begin
                        // Only G2 gets here without a fault: start tracking at P1
                        r_state <= c_ST_SYNC;
                        r_phase <= 2'd0;
                        r_valid <= 1'b1;
                    end else if (w_cls != w_cur_cls) begin
                        // Legal advance to the next phase
                        r_state <= c_ST_RUN;
                        r_phase <= w_nxt_phase;
                        r_valid <= 1'b1;
                        if (w_nxt_phase == 2'd0) r_cnt <= r_cnt + 8'd1;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_light_monitor
//  Description : Scoreboard bench for traffic_light_monitor with shortened
//                dwell targets (LONG 9, SHORT 3, TOL 1). Dwell expectations
//                follow TRAFFIC_MON_TIMING_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_light_monitor;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] light1 = 3'b000;
    logic [1:0] light2 = 2'b00;
    logic       clr    = 1'b0;
    logic [1:0] phase;
    logic       phase_valid;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] cycle_cnt;

    int n_total = 0;
    int n_bad   = 0;

    // Expected {phase, phase_valid, fault, fault_code, cycle_cnt}
    logic [14:0] sb_q[$];

    traffic_light_monitor #(
        .LONG_CYC  (9),
        .SHORT_CYC (3),
        .TOL       (1)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .light1      (light1),
        .light2      (light2),
        .clr         (clr),
        .phase       (phase),
        .phase_valid (phase_valid),
        .fault       (fault),
        .fault_code  (fault_code),
        .cycle_cnt   (cycle_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] ev(input logic [1:0] p, input logic v,
                                       input logic f, input logic [2:0] c,
                                       input logic [7:0] n);
        return {p, v, f, c, n};
    endfunction

    task automatic check(input string tag, input logic [14:0] got, input logic [14:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got ph=%0d v=%0d f=%0d code=%0d cnt=%0d, want ph=%0d v=%0d f=%0d code=%0d cnt=%0d",
                     tag, got[14:13], got[12], got[11], got[10:8], got[7:0],
                     exp[14:13], exp[12], exp[11], exp[10:8], exp[7:0]);
        end
    endtask

    // Drive a pattern for n cycles, pushing the expectation for each clock and
    // comparing it against the outputs one step after the edge.
    task automatic step(input string tag, input logic [2:0] l1, input logic [1:0] l2,
                        input logic c, input int n, input logic [14:0] e);
        logic [14:0] x;
        for (int i = 0; i < n; i++) begin
            sb_q.push_back(e);
            light1 = l1;
            light2 = l2;
            clr    = c;
            @(posedge clk);
            #1;
            x = sb_q.pop_front();
            check(tag, {phase, phase_valid, fault, fault_code, cycle_cnt}, x);
        end
        clr = 1'b0;
    endtask

    initial begin
        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        check("reset", {phase, phase_valid, fault, fault_code, cycle_cnt}, ev(0, 0, 0, 0, 0));
        rst_n = 1'b1;

        // 1: full legal cycle
        step("t1_off",  3'b000, 2'b00, 0, 2, ev(0, 0, 0, 0, 0));
        step("t1_p1s",  3'b100, 2'b01, 0, 9, ev(0, 1, 0, 0, 0));
        step("t1_p2",   3'b010, 2'b10, 0, 3, ev(1, 1, 0, 0, 0));
        step("t1_p3",   3'b001, 2'b10, 0, 9, ev(2, 1, 0, 0, 0));
        step("t1_p4",   3'b010, 2'b10, 0, 3, ev(3, 1, 0, 0, 0));
        step("t1_p1",   3'b100, 2'b01, 0, 9, ev(0, 1, 0, 0, 1));

        // 3: P1 in RUN held 6 clocks, then yellow
        step("t3_p2",   3'b010, 2'b10, 0, 3, ev(1, 1, 0, 0, 1));
        step("t3_p3",   3'b001, 2'b10, 0, 9, ev(2, 1, 0, 0, 1));
        step("t3_p4",   3'b010, 2'b10, 0, 3, ev(3, 1, 0, 0, 1));
        step("t3_p1",   3'b100, 2'b01, 0, 6, ev(0, 1, 0, 0, 2));
`ifdef TRAFFIC_MON_TIMING_EN
        step("t3_short", 3'b010, 2'b10, 0, 1, ev(0, 0, 1, 4, 2));
`else
        step("t3_short", 3'b010, 2'b10, 0, 1, ev(1, 1, 0, 0, 2));
`endif
        step("t3_clr",  3'b000, 2'b00, 1, 1, ev(0, 0, 0, 0, 2));

        // 4: clr outside FAULT, then P1 straight to G1
        step("t4_clr_idle", 3'b000, 2'b00, 1, 1, ev(0, 0, 0, 0, 2));
        step("t4_p1",   3'b100, 2'b01, 0, 3, ev(0, 1, 0, 0, 2));
        step("t4_seq",  3'b001, 2'b10, 0, 1, ev(0, 0, 1, 3, 2));
        step("t4_hold", 3'b100, 2'b01, 0, 2, ev(0, 0, 1, 3, 2));
        step("t4_clr",  3'b000, 2'b00, 1, 1, ev(0, 0, 0, 0, 2));

        // 2: conflict while running P1; later legal patterns are ignored
        step("t2_p1s",  3'b100, 2'b01, 0, 2, ev(0, 1, 0, 0, 2));
        step("t2_p2",   3'b010, 2'b10, 0, 3, ev(1, 1, 0, 0, 2));
        step("t2_p3",   3'b001, 2'b10, 0, 9, ev(2, 1, 0, 0, 2));
        step("t2_p4",   3'b010, 2'b10, 0, 3, ev(3, 1, 0, 0, 2));
        step("t2_p1",   3'b100, 2'b01, 0, 9, ev(0, 1, 0, 0, 3));
        step("t2_conf", 3'b001, 2'b01, 0, 1, ev(0, 0, 1, 1, 3));
        step("t2_g2",   3'b100, 2'b01, 0, 2, ev(0, 0, 1, 1, 3));
        step("t2_y",    3'b010, 2'b10, 0, 2, ev(0, 0, 1, 1, 3));
        step("t2_clr",  3'b000, 2'b00, 1, 1, ev(0, 0, 0, 0, 3));

        // 5: P1 in RUN held too long, then bad encoding and clr racing a fault
        step("t5_p1s",  3'b100, 2'b01, 0, 2, ev(0, 1, 0, 0, 3));
        step("t5_p2",   3'b010, 2'b10, 0, 3, ev(1, 1, 0, 0, 3));
        step("t5_p3",   3'b001, 2'b10, 0, 9, ev(2, 1, 0, 0, 3));
        step("t5_p4",   3'b010, 2'b10, 0, 3, ev(3, 1, 0, 0, 3));
        step("t5_p1",   3'b100, 2'b01, 0, 12, ev(0, 1, 0, 0, 4));
`ifdef TRAFFIC_MON_TIMING_EN
        step("t5_long", 3'b100, 2'b01, 0, 1, ev(0, 0, 1, 5, 4));
`else
        step("t5_long", 3'b100, 2'b01, 0, 1, ev(0, 1, 0, 0, 4));
`endif
        step("t5_clr",  3'b000, 2'b00, 1, 1, ev(0, 0, 0, 0, 4));
        step("t5_enc",  3'b011, 2'b10, 0, 1, ev(0, 0, 1, 2, 4));
        step("t5_clr_conf", 3'b001, 2'b01, 1, 1, ev(0, 0, 1, 1, 4));
        step("t5_clr2", 3'b000, 2'b00, 1, 1, ev(0, 0, 0, 0, 4));

        // 6: asynchronous reset mid-P3, then resume with an unchecked SYNC phase
        step("t6_p1s",  3'b100, 2'b01, 0, 2, ev(0, 1, 0, 0, 4));
        step("t6_p2",   3'b010, 2'b10, 0, 3, ev(1, 1, 0, 0, 4));
        step("t6_p3",   3'b001, 2'b10, 0, 4, ev(2, 1, 0, 0, 4));
        rst_n = 1'b0;
        #1;
        check("t6_rst_async", {phase, phase_valid, fault, fault_code, cycle_cnt}, ev(0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check("t6_rst_hold", {phase, phase_valid, fault, fault_code, cycle_cnt}, ev(0, 0, 0, 0, 0));
        rst_n = 1'b1;
        step("t6_sync", 3'b100, 2'b01, 0, 20, ev(0, 1, 0, 0, 0));
        step("t6_p2",   3'b010, 2'b10, 0, 3, ev(1, 1, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
